// File: rtl/regfile_pkg.sv
// Shared constants for the 2-write/2-read register file.
// Default geometry; modules derive their own byte count from DATA_W.
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NBYTE      = DATA_W_DEF / 8;
endpackage

// File: rtl/regfile_2w2r_if.sv
// Write, reserve and read bundle of the register file.
// master drives addresses/data, slave is the register file.
interface regfile_2w2r_if import regfile_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic                  we_a;
    logic [ADDR_W-1:0]     waddr_a;
    logic [DATA_W-1:0]     wdata_a;
    logic [DATA_W/8-1:0]   wbe_a;
    logic                  we_b;
    logic [ADDR_W-1:0]     waddr_b;
    logic [DATA_W-1:0]     wdata_b;
    logic [DATA_W/8-1:0]   wbe_b;
    logic                  rsv_en;
    logic [ADDR_W-1:0]     rsv_addr;
    logic [ADDR_W-1:0]     raddr1;
    logic [DATA_W-1:0]     rdata1;
    logic                  busy1;
    logic [ADDR_W-1:0]     raddr2;
    logic [DATA_W-1:0]     rdata2;
    logic                  busy2;

    modport master (
        output we_a, waddr_a, wdata_a, wbe_a,
        output we_b, waddr_b, wdata_b, wbe_b,
        output rsv_en, rsv_addr, raddr1, raddr2,
        input  rdata1, busy1, rdata2, busy2
    );

    modport slave (
        input  we_a, waddr_a, wdata_a, wbe_a,
        input  we_b, waddr_b, wdata_b, wbe_b,
        input  rsv_en, rsv_addr, raddr1, raddr2,
        output rdata1, busy1, rdata2, busy2
    );
endinterface

// File: rtl/regfile_wmerge.sv
// Byte-wise merge of the two write ports onto a stored word.
// Port B owns any byte both ports enable.
module regfile_wmerge import regfile_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   i_old,
    input  logic [DATA_W-1:0]   i_wdata_a,
    input  logic [DATA_W/8-1:0] i_wbe_a,
    input  logic                i_hit_a,
    input  logic [DATA_W-1:0]   i_wdata_b,
    input  logic [DATA_W/8-1:0] i_wbe_b,
    input  logic                i_hit_b,
    output logic [DATA_W-1:0]   o_new
);
    always_comb begin
        o_new = i_old;
        for (int k = 0; k < DATA_W / 8; k++) begin
            if (i_hit_b && i_wbe_b[k]) begin
                o_new[8*k +: 8] = i_wdata_b[8*k +: 8];
            end else if (i_hit_a && i_wbe_a[k]) begin
                o_new[8*k +: 8] = i_wdata_a[8*k +: 8];
            end
        end
    end
endmodule

// File: rtl/regfile_2w2r.sv
// 2-write/2-read register file with byte enables, bypass,
// optional registered read and a per-register busy scoreboard.
module regfile_2w2r import regfile_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    parameter bit RD_REG   = 1'b0
) (
    input logic           clk,
    input logic           rst,
    regfile_2w2r_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [NREG];
    logic [NREG-1:0]   r_busy;

    logic [DATA_W-1:0] w_next [NREG];
    logic [NREG-1:0]   w_hit_a;
    logic [NREG-1:0]   w_hit_b;
    logic [NREG-1:0]   w_busy_nxt;
    logic [DATA_W-1:0] w_byp1;
    logic [DATA_W-1:0] w_byp2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_b1;
    logic              w_b2;

    // Register 0 never matches a write when hardwired to zero
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_hit_a[i] = bus.we_a && (bus.waddr_a == ADDR_W'(i));
            w_hit_b[i] = bus.we_b && (bus.waddr_b == ADDR_W'(i));
        end
        if (ZERO_REG) begin
            w_hit_a[0] = 1'b0;
            w_hit_b[0] = 1'b0;
        end
    end

    // A reservation outranks a same-cycle writeback
    always_comb begin
        w_busy_nxt = r_busy & ~(w_hit_a | w_hit_b);
        if (bus.rsv_en) begin
            w_busy_nxt[bus.rsv_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_wr
        regfile_wmerge #(.DATA_W(DATA_W)) u_wm (
            .i_old     (r_mem[g]),
            .i_wdata_a (bus.wdata_a),
            .i_wbe_a   (bus.wbe_a),
            .i_hit_a   (w_hit_a[g]),
            .i_wdata_b (bus.wdata_b),
            .i_wbe_b   (bus.wbe_b),
            .i_hit_b   (w_hit_b[g]),
            .o_new     (w_next[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= w_next[i];
            end
            r_busy <= w_busy_nxt;
        end
    end

    regfile_wmerge #(.DATA_W(DATA_W)) u_byp1 (
        .i_old     (r_mem[bus.raddr1]),
        .i_wdata_a (bus.wdata_a),
        .i_wbe_a   (bus.wbe_a),
        .i_hit_a   (w_hit_a[bus.raddr1]),
        .i_wdata_b (bus.wdata_b),
        .i_wbe_b   (bus.wbe_b),
        .i_hit_b   (w_hit_b[bus.raddr1]),
        .o_new     (w_byp1)
    );

    regfile_wmerge #(.DATA_W(DATA_W)) u_byp2 (
        .i_old     (r_mem[bus.raddr2]),
        .i_wdata_a (bus.wdata_a),
        .i_wbe_a   (bus.wbe_a),
        .i_hit_a   (w_hit_a[bus.raddr2]),
        .i_wdata_b (bus.wdata_b),
        .i_wbe_b   (bus.wbe_b),
        .i_hit_b   (w_hit_b[bus.raddr2]),
        .o_new     (w_byp2)
    );

    always_comb begin
        w_rd1 = BYPASS ? w_byp1 : r_mem[bus.raddr1];
        w_rd2 = BYPASS ? w_byp2 : r_mem[bus.raddr2];
        w_b1  = BYPASS ? w_busy_nxt[bus.raddr1] : r_busy[bus.raddr1];
        w_b2  = BYPASS ? w_busy_nxt[bus.raddr2] : r_busy[bus.raddr2];
    end

    if (RD_REG) begin : g_rreg
        logic [DATA_W-1:0] r_rdata1;
        logic [DATA_W-1:0] r_rdata2;
        logic              r_busy1;
        logic              r_busy2;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rdata1 <= '0;
                r_rdata2 <= '0;
                r_busy1  <= 1'b0;
                r_busy2  <= 1'b0;
            end else begin
                r_rdata1 <= w_rd1;
                r_rdata2 <= w_rd2;
                r_busy1  <= w_b1;
                r_busy2  <= w_b2;
            end
        end

        assign bus.rdata1 = r_rdata1;
        assign bus.rdata2 = r_rdata2;
        assign bus.busy1  = r_busy1;
        assign bus.busy2  = r_busy2;
    end else begin : g_rcomb
        assign bus.rdata1 = w_rd1;
        assign bus.rdata2 = w_rd2;
        assign bus.busy1  = w_b1;
        assign bus.busy2  = w_b2;
    end
endmodule

// File: tb/tb_regfile_2w2r.sv
// Bench for regfile_2w2r: three configurations share one stimulus.
// cfg0 comb+bypass, cfg1 registered+bypass, cfg2 comb without bypass.
module tb_regfile_2w2r;
    logic        clk;
    logic        rst;
    logic        we_a;
    logic [4:0]  waddr_a;
    logic [31:0] wdata_a;
    logic [3:0]  wbe_a;
    logic        we_b;
    logic [4:0]  waddr_b;
    logic [31:0] wdata_b;
    logic [3:0]  wbe_b;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;

    logic [31:0] rd1 [3];
    logic [31:0] rd2 [3];
    logic        b1  [3];
    logic        b2  [3];

    int tests;
    int fails;

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        regfile_2w2r_if #(.DATA_W(32), .ADDR_W(5)) u_bus ();

        assign u_bus.we_a     = we_a;
        assign u_bus.waddr_a  = waddr_a;
        assign u_bus.wdata_a  = wdata_a;
        assign u_bus.wbe_a    = wbe_a;
        assign u_bus.we_b     = we_b;
        assign u_bus.waddr_b  = waddr_b;
        assign u_bus.wdata_b  = wdata_b;
        assign u_bus.wbe_b    = wbe_b;
        assign u_bus.rsv_en   = rsv_en;
        assign u_bus.rsv_addr = rsv_addr;
        assign u_bus.raddr1   = raddr1;
        assign u_bus.raddr2   = raddr2;
        assign rd1[g] = u_bus.rdata1;
        assign rd2[g] = u_bus.rdata2;
        assign b1[g]  = u_bus.busy1;
        assign b2[g]  = u_bus.busy2;

        regfile_2w2r #(
            .DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1),
            .BYPASS(g != 2), .RD_REG(g == 1)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        we_a = 0; waddr_a = 0; wdata_a = 0; wbe_a = 0;
        we_b = 0; waddr_b = 0; wdata_b = 0; wbe_b = 0;
        rsv_en = 0; rsv_addr = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        raddr1 = 5;
        raddr2 = 31;
        repeat (2) @(negedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if ({rd1[c], rd2[c], b1[c], b2[c]} !== 66'd0) begin
                fails++;
                $display("FAIL reset cfg%0d: rd1=%h rd2=%h b=%b%b want 0",
                         c, rd1[c], rd2[c], b1[c], b2[c]);
            end
        end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_byte_write();
        @(negedge clk);
        raddr1 = 5;
        we_a = 1; waddr_a = 5; wdata_a = 32'hAAAA_BBBB; wbe_a = 4'hF;
        @(negedge clk);
        we_a = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (rd1[c] !== 32'hAAAA_BBBB) begin
                fails++;
                $display("FAIL full_write cfg%0d: got %h want AAAABBBB",
                         c, rd1[c]);
            end
        end
        we_a = 1; wdata_a = 32'h1234_5678; wbe_a = 4'b0011;
        @(negedge clk);
        we_a = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (rd1[c] !== 32'hAAAA_5678) begin
                fails++;
                $display("FAIL byte_write cfg%0d: got %h want AAAA5678",
                         c, rd1[c]);
            end
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        raddr1 = 15;
        raddr2 = 15;
        we_a = 1; waddr_a = 15; wdata_a = 32'h1111_1111; wbe_a = 4'hF;
        we_b = 1; waddr_b = 15; wdata_b = 32'h2222_2222; wbe_b = 4'b0110;
        @(negedge clk);
        idle();
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (rd1[c] !== 32'h1122_2211 || rd2[c] !== 32'h1122_2211) begin
                fails++;
                $display("FAIL dual_merge cfg%0d: got %h/%h want 11222211",
                         c, rd1[c], rd2[c]);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        raddr1 = 7;
        we_a = 1; waddr_a = 7; wdata_a = 32'hDEAD_BEEF; wbe_a = 4'hF;
        #1;
        tests++;
        if (rd1[0] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL bypass_same cfg0: got %h want DEADBEEF", rd1[0]);
        end
        tests++;
        if (rd1[2] !== 32'h0) begin
            fails++;
            $display("FAIL nobypass_old cfg2: got %h want 0", rd1[2]);
        end
        tests++;
        if (rd1[1] !== 32'h1122_2211) begin
            fails++;
            $display("FAIL rdreg_latency cfg1: got %h want 11222211", rd1[1]);
        end
        @(negedge clk);
        idle();
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (rd1[c] !== 32'hDEAD_BEEF) begin
                fails++;
                $display("FAIL bypass_after cfg%0d: got %h want DEADBEEF",
                         c, rd1[c]);
            end
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        raddr1 = 0;
        raddr2 = 0;
        we_a = 1; waddr_a = 0; wdata_a = 32'hFFFF_FFFF; wbe_a = 4'hF;
        we_b = 1; waddr_b = 0; wdata_b = 32'hFFFF_FFFF; wbe_b = 4'hF;
        rsv_en = 1; rsv_addr = 0;
        #1;
        tests++;
        if (rd1[0] !== 32'h0 || b1[0] !== 1'b0) begin
            fails++;
            $display("FAIL zero_comb cfg0: got %h busy %b want 0/0",
                     rd1[0], b1[0]);
        end
        @(negedge clk);
        idle();
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if ({rd1[c], rd2[c], b1[c], b2[c]} !== 66'd0) begin
                fails++;
                $display("FAIL zero_reg cfg%0d: rd=%h busy=%b want 0/0",
                         c, rd1[c], b1[c]);
            end
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        raddr1 = 9;
        raddr2 = 12;
        rsv_en = 1; rsv_addr = 9;
        #1;
        tests++;
        if (b1[0] !== 1'b1 || b1[2] !== 1'b0) begin
            fails++;
            $display("FAIL rsv_comb: cfg0 %b cfg2 %b want 1/0", b1[0], b1[2]);
        end
        @(negedge clk);
        idle();
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (b1[c] !== 1'b1) begin
                fails++;
                $display("FAIL rsv_set cfg%0d: got %b want 1", c, b1[c]);
            end
        end
        rsv_en = 1; rsv_addr = 9;
        we_b = 1; waddr_b = 9; wdata_b = 32'hCAFE_F00D; wbe_b = 4'hF;
        @(negedge clk);
        idle();
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (b1[c] !== 1'b1 || rd1[c] !== 32'hCAFE_F00D) begin
                fails++;
                $display("FAIL rsv_wins cfg%0d: busy %b data %h want 1/CAFEF00D",
                         c, b1[c], rd1[c]);
            end
        end
        we_a = 1; waddr_a = 9; wdata_a = 32'hFFFF_FFFF; wbe_a = 4'h0;
        @(negedge clk);
        idle();
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (b1[c] !== 1'b0 || rd1[c] !== 32'hCAFE_F00D) begin
                fails++;
                $display("FAIL wbe0_clear cfg%0d: busy %b data %h want 0/CAFEF00D",
                         c, b1[c], rd1[c]);
            end
        end
        rsv_en = 1; rsv_addr = 12;
        @(negedge clk);
        rsv_en = 1; rsv_addr = 9;
        @(negedge clk);
        idle();
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (b1[c] !== 1'b1 || b2[c] !== 1'b1) begin
                fails++;
                $display("FAIL two_busy cfg%0d: got %b%b want 11",
                         c, b1[c], b2[c]);
            end
        end
        #2;
        rst = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if ({rd1[c], b1[c], b2[c]} !== 34'd0) begin
                fails++;
                $display("FAIL async_rst cfg%0d: rd %h busy %b%b want 0",
                         c, rd1[c], b1[c], b2[c]);
            end
        end
        @(negedge clk);
        rst = 1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        logic [31:0] m  [32];
        logic [31:0] nm [32];
        logic [31:0] bz;
        logic [31:0] nb;
        logic [65:0] exp_reg;
        logic [65:0] exp_new;
        logic [65:0] exp_old;
        rst = 0;
        idle();
        repeat (2) @(negedge clk);
        rst = 1;
        for (int i = 0; i < 32; i++) m[i] = 0;
        bz = 0;
        exp_reg = 0;
        repeat (400) begin
            we_a = 1'($urandom_range(0, 1));
            waddr_a = rnd_addr();
            wdata_a = $urandom;
            wbe_a = 4'($urandom_range(0, 15));
            we_b = 1'($urandom_range(0, 1));
            waddr_b = ($urandom_range(0, 2) == 0) ? waddr_a : rnd_addr();
            wdata_b = $urandom;
            wbe_b = 4'($urandom_range(0, 15));
            rsv_en = 1'($urandom_range(0, 1));
            rsv_addr = ($urandom_range(0, 3) == 0) ? waddr_b : rnd_addr();
            raddr1 = ($urandom_range(0, 1) == 0) ? waddr_a : rnd_addr();
            raddr2 = ($urandom_range(0, 1) == 0) ? waddr_b : rnd_addr();
            nm = m;
            nb = bz;
            for (int k = 0; k < 4; k++) begin
                if (we_a && wbe_a[k]) nm[waddr_a][8*k +: 8] = wdata_a[8*k +: 8];
            end
            for (int k = 0; k < 4; k++) begin
                if (we_b && wbe_b[k]) nm[waddr_b][8*k +: 8] = wdata_b[8*k +: 8];
            end
            if (we_a) nb[waddr_a] = 1'b0;
            if (we_b) nb[waddr_b] = 1'b0;
            if (rsv_en) nb[rsv_addr] = 1'b1;
            nm[0] = 0;
            nb[0] = 1'b0;
            exp_new = {nm[raddr1], nm[raddr2], nb[raddr1], nb[raddr2]};
            exp_old = {m[raddr1], m[raddr2], bz[raddr1], bz[raddr2]};
            #1;
            tests++;
            if ({rd1[0], rd2[0], b1[0], b2[0]} !== exp_new) begin
                fails++;
                $display("FAIL rand cfg0: got %h %h %b%b want %h",
                         rd1[0], rd2[0], b1[0], b2[0], exp_new);
            end
            tests++;
            if ({rd1[1], rd2[1], b1[1], b2[1]} !== exp_reg) begin
                fails++;
                $display("FAIL rand cfg1: got %h %h %b%b want %h",
                         rd1[1], rd2[1], b1[1], b2[1], exp_reg);
            end
            tests++;
            if ({rd1[2], rd2[2], b1[2], b2[2]} !== exp_old) begin
                fails++;
                $display("FAIL rand cfg2: got %h %h %b%b want %h",
                         rd1[2], rd2[2], b1[2], b2[2], exp_old);
            end
            @(posedge clk);
            m = nm;
            bz = nb;
            exp_reg = exp_new;
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 0;
        raddr1 = 0;
        raddr2 = 0;
        idle();
        test_reset();
        test_byte_write();
        test_dual_write();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
